// File: rtl/toy_mem_pkg.sv
// rtl/toy_mem_pkg.sv - shared types and constants for the toy memory arbiter
package toy_mem_pkg;

  localparam int AW_DEF         = 30;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

  localparam logic RW_RD = 1'b0;
  localparam logic RW_WR = 1'b1;

endpackage

// File: rtl/toy_arb_starve_ctr.sv
// rtl/toy_arb_starve_ctr.sv - saturating count of data grants taken while a fetch waits
module toy_arb_starve_ctr #(
  parameter int STARVE_MAX = toy_mem_pkg::STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_grant_i,
  input  logic i_grant_i,
  input  logic i_req_i,
  output logic force_fetch_o
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_grant_i)
      cnt_d = '0;
    else if (d_grant_i && i_req_i && (cnt_q != SMAX))
      cnt_d = cnt_q + 4'd1;
  end

  assign force_fetch_o = i_req_i && (cnt_q == SMAX);

endmodule

// File: rtl/toy_mem_arbiter.sv
// rtl/toy_mem_arbiter.sv - fetch/data arbiter onto one single-ported memory
// Optional fetch starvation guard enabled by TOY_MEM_ARB_FAIR_EN.
module toy_mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic          M_RDY,
  input  logic [DW-1:0] M_RDATA
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("STARVE_MAX must lie in 1..15");
  end

  arb_state_e    state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_rw_q, m_rw_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_grant, i_grant, force_fetch;

`ifdef TOY_MEM_ARB_FAIR_EN
  toy_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i         (CLK),
    .rst_i         (RST),
    .d_grant_i     (d_grant),
    .i_grant_i     (i_grant),
    .i_req_i       (I_REQ),
    .force_fetch_o (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_rw_q    <= RW_RD;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    d_grant   = 1'b0;
    i_grant   = 1'b0;
    case (state_q)
      // Data belongs to an older instruction, so it wins unless the guard forces a fetch.
      IDLE: begin
        if (D_REQ && !force_fetch) begin
          d_grant   = 1'b1;
          m_req_d   = 1'b1;
          m_rw_d    = D_RW;
          m_addr_d  = D_ADDR;
          m_wdata_d = D_WDATA;
          state_d   = DBUSY;
        end else if (I_REQ) begin
          i_grant  = 1'b1;
          m_req_d  = 1'b1;
          m_rw_d   = RW_RD;
          m_addr_d = I_ADDR;
          state_d  = IBUSY;
        end
      end
      IBUSY: begin
        if (M_RDY) begin
          m_req_d   = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = M_RDATA;
          state_d   = IDLE;
        end
      end
      DBUSY: begin
        if (M_RDY) begin
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          if (m_rw_q == RW_RD) d_rdata_d = M_RDATA;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign M_REQ   = m_req_q;
  assign M_RW    = m_rw_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;
  assign I_ACK   = i_ack_q;
  assign I_RDATA = i_rdata_q;
  assign D_ACK   = d_ack_q;
  assign D_RDATA = d_rdata_q;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// tb/tb_toy_mem_arbiter.sv - scoreboard bench for toy_mem_arbiter
module tb_toy_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_REQ = 1'b0;
  logic [29:0] I_ADDR = '0;
  logic        I_ACK;
  logic [31:0] I_RDATA;
  logic        D_REQ = 1'b0;
  logic        D_RW = 1'b0;
  logic [29:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  logic        M_REQ;
  logic        M_RW;
  logic [29:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic        M_RDY = 1'b0;
  logic [31:0] M_RDATA = '0;

  toy_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_RDY(M_RDY), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_i;
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        m_exp_q[$];
  txn_t        a_exp_q[$];
  logic [31:0] mem [logic [29:0]];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rdy_delay = 0;
  int          ack_cnt = 0;
  logic [31:0] d_last = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {2'b10, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic push_txn(input bit is_i, input bit wr, input logic [29:0] a, input logic [31:0] wd);
    txn_t t;
    t.is_i  = is_i;
    t.wr    = is_i ? 1'b0 : wr;
    t.addr  = a;
    t.wdata = wd;
    t.rdata = mem_rd(a);
    m_exp_q.push_back(t);
    a_exp_q.push_back(t);
  endtask

  task automatic xfer(input bit is_i, input bit wr, input logic [29:0] a, input logic [31:0] wd);
    int n;
    push_txn(is_i, wr, a, wd);
    @(negedge CLK);
    if (is_i) begin
      I_REQ = 1'b1; I_ADDR = a;
    end else begin
      D_REQ = 1'b1; D_RW = wr; D_ADDR = a; D_WDATA = wd;
    end
    for (n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (is_i ? I_ACK : D_ACK) break;
    end
    if (n == 50) chk("xfer_timeout", 0, 1);
    if (is_i) I_REQ = 1'b0;
    else      D_REQ = 1'b0;
  endtask

  // Memory model: checks grant order and bus hold, completes after rdy_delay wait cycles.
  initial begin
    bit                 act = 1'b0;
    int                 cnt = 0;
    logic [62:0]        held = '0;
    txn_t               t;
    forever begin
      @(negedge CLK);
      if (M_REQ) begin
        if (!act) begin
          act  = 1'b1;
          cnt  = 0;
          held = {M_RW, M_ADDR, M_WDATA};
          if (m_exp_q.size() == 0) chk("m_unexpected", 1, 0);
          else begin
            t = m_exp_q.pop_front();
            chk("m_addr", M_ADDR, t.addr);
            chk("m_rw", M_RW, t.wr);
            if (t.wr) chk("m_wdata", M_WDATA, t.wdata);
          end
        end else begin
          chk("m_hold", {M_RW, M_ADDR, M_WDATA}, held);
        end
        if (cnt >= rdy_delay) begin
          M_RDY   = 1'b1;
          M_RDATA = mem_rd(M_ADDR);
          if (M_RW) mem[M_ADDR] = M_WDATA;
          act = 1'b0;
        end else begin
          M_RDY = 1'b0;
          cnt++;
        end
      end else begin
        act     = 1'b0;
        M_RDY   = 1'($urandom_range(0, 1));
        M_RDATA = $urandom;
      end
    end
  end

  // ACK monitor: port order, returned data, pulse width, exclusivity.
  initial begin
    bit   pi = 1'b0, pd = 1'b0;
    txn_t t;
    forever begin
      @(negedge CLK);
      if (RST) begin
        d_last = '0; pi = 1'b0; pd = 1'b0;
      end else begin
        if (I_ACK && D_ACK) chk("ack_overlap", 1, 0);
        if ((I_ACK && pi) || (D_ACK && pd)) chk("ack_width", 1, 0);
        if (I_ACK || D_ACK) begin
          ack_cnt++;
          if (a_exp_q.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            t = a_exp_q.pop_front();
            chk("ack_port", I_ACK, t.is_i);
            if (I_ACK) chk("i_rdata", I_RDATA, t.rdata);
            else begin
              if (!t.wr) d_last = t.rdata;
              chk("d_rdata", D_RDATA, d_last);
            end
          end
        end
        pi = I_ACK; pd = D_ACK;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dd, id;
    int na, n, base;
    mem[30'h40] = 32'hDEAD_BEEF;
    repeat (3) @(negedge CLK);
    chk("rst_ctl", {M_REQ, M_RW, I_ACK, D_ACK}, 0);
    chk("rst_buses", {M_ADDR, M_WDATA}, 0);
    chk("rst_rdata", {I_RDATA, D_RDATA}, 0);
    RST = 1'b0;

    // single fetch, M_RDY immediately
    rdy_delay = 0;
    push_txn(1'b1, 1'b0, 30'h40, '0);
    @(negedge CLK);
    I_REQ = 1'b1; I_ADDR = 30'h40;
    @(negedge CLK);
    chk("f_mreq_t1", M_REQ, 1);
    chk("f_noack_t1", I_ACK, 0);
    @(negedge CLK);
    chk("f_ack_t2", I_ACK, 1);
    chk("f_rdata", I_RDATA, 32'hDEAD_BEEF);
    I_REQ = 1'b0;
    @(negedge CLK);
    chk("f_ack_drop", I_ACK, 0);

    // write with two wait cycles: bus stable t+1..t+3, ACK at t+4
    rdy_delay = 2;
    push_txn(1'b0, 1'b1, 30'h80, 32'h1234_5678);
    @(negedge CLK);
    D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h80; D_WDATA = 32'h1234_5678;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      D_ADDR = 30'h3FF; D_WDATA = 32'hFFFF_FFFF; D_RW = 1'b0;
      chk("w_mreq", M_REQ, 1);
      chk("w_rw", M_RW, 1);
      chk("w_noack", D_ACK, 0);
    end
    @(negedge CLK);
    chk("w_ack_t4", D_ACK, 1);
    chk("w_rdata_kept", D_RDATA, 0);
    D_REQ = 1'b0;
    rdy_delay = 1;
    xfer(1'b0, 1'b0, 30'h80, '0);
    chk("w_readback", D_RDATA, 32'h1234_5678);

    // collision: data read wins, then fetch
    push_txn(1'b0, 1'b0, 30'h90, '0);
    push_txn(1'b1, 1'b0, 30'h48, '0);
    @(negedge CLK);
    D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h90;
    I_REQ = 1'b1; I_ADDR = 30'h48;
    dd = 1'b0; id = 1'b0;
    for (n = 0; n < 60 && !(dd && id); n++) begin
      @(negedge CLK);
      if (D_ACK) begin dd = 1'b1; D_REQ = 1'b0; end
      if (I_ACK) begin id = 1'b1; I_REQ = 1'b0; end
    end
    chk("col_done", {dd, id}, 2'b11);

    // starvation: both held high for 12 ACKs, then data drops, one more fetch
    rdy_delay = 0;
    for (int k = 0; k < 12; k++) begin
`ifdef TOY_MEM_ARB_FAIR_EN
      push_txn((k % 4) == 3, 1'b0, ((k % 4) == 3) ? 30'h44 : 30'h90, '0);
`else
      push_txn(1'b0, 1'b0, 30'h90, '0);
`endif
    end
    push_txn(1'b1, 1'b0, 30'h44, '0);
    @(negedge CLK);
    D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h90;
    I_REQ = 1'b1; I_ADDR = 30'h44;
    na = 0;
    for (n = 0; n < 200 && na < 13; n++) begin
      @(negedge CLK);
      if (I_ACK || D_ACK) begin
        na++;
        if (na == 12) D_REQ = 1'b0;
        if (na == 13) I_REQ = 1'b0;
      end
    end
    chk("starve_acks", na, 13);

    // random single accesses over a small address window
    for (int k = 0; k < 16; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      rdy_delay = $urandom_range(0, 3);
      xfer(kind == 0, kind == 2, 30'h100 + 30'($urandom_range(0, 7)), $urandom);
    end
    chk("sb_drained", {32'(a_exp_q.size()), 32'(m_exp_q.size())}, 0);

    // reset during IBUSY: immediate M_REQ drop, no ACK afterwards
    rdy_delay = 20;
    push_txn(1'b1, 1'b0, 30'h10, '0);
    @(negedge CLK);
    I_REQ = 1'b1; I_ADDR = 30'h10;
    repeat (2) @(negedge CLK);
    chk("rst_pre_mreq", {M_REQ, M_ADDR}, {1'b1, 30'h10});
    RST = 1'b1;
    #1;
    chk("rst_async_mreq", M_REQ, 0);
    chk("rst_mid_ctl", {M_RW, I_ACK, D_ACK}, 0);
    chk("rst_mid_buses", {M_ADDR, M_WDATA}, 0);
    chk("rst_mid_rdata", {I_RDATA, D_RDATA}, 0);
    I_REQ = 1'b0;
    a_exp_q.delete();
    m_exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    base = ack_cnt;
    repeat (8) @(negedge CLK);
    chk("rst_no_ack", ack_cnt, base);
    chk("rst_idle_mreq", M_REQ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toy_mem_arbiter.md
# toy_mem_arbiter

- Shares one single-ported memory between the RISC_TOY fetch port (IREQ/IADDR/INSTR side) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA side).
- Registers the granted request onto the memory bus and holds it until the memory completes.
- Returns data with a one-cycle ACK pulse to the granted requester. The core stalls its fetch or MEM stage while the matching ACK is absent.
- Data accesses win by default; an optional starvation guard bounds fetch wait.

## Interface
- AW, 30: word-address width.
- DW, 32: data width.
- STARVE_MAX, 3: consecutive data grants tolerated while a fetch waits. Used only with the fairness macro; legal range 1..15.

Ports (all outputs registered):
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- I_REQ  in  1  fetch request; held until I_ACK.
- I_ADDR  in  AW  fetch word address.
- I_ACK  out  1  one-cycle completion pulse for fetch.
- I_RDATA  out  DW  fetched instruction; valid when I_ACK=1, held until the next fetch completes.
- D_REQ  in  1  data request; held until D_ACK.
- D_RW  in  1  1 = write, 0 = read.
- D_ADDR  in  AW  data word address.
- D_WDATA  in  DW  write data.
- D_ACK  out  1  one-cycle completion pulse for data, for reads and writes.
- D_RDATA  out  DW  read data; updated only on read completion, unchanged on write.
- M_REQ  out  1  memory request.
- M_RW  out  1  memory direction, same encoding as D_RW.
- M_ADDR  out  AW  memory address.
- M_WDATA  out  DW  memory write data.
- M_RDY  in  1  memory completes the access in this cycle when M_REQ=1.
- M_RDATA  in  DW  read data, valid in the cycle M_REQ & M_RDY.

## Operation

States: IDLE, IBUSY, DBUSY.

- **IDLE**
  - If D_REQ wins arbitration: latch D_RW/D_ADDR/D_WDATA into M_*, set M_REQ=1, go to DBUSY.
  - Else if I_REQ: latch I_ADDR, set M_RW=0, M_REQ=1, go to IBUSY.
  - Else stay in IDLE.
- **IBUSY / DBUSY**
  - M_* held stable.
  - On M_RDY=1: drop M_REQ, pulse the matching ACK next cycle, capture M_RDATA into I_RDATA (IBUSY) or into D_RDATA (DBUSY, reads only), return to IDLE.
- **Arbitration:** D_REQ beats I_REQ. Data belongs to an older instruction, so this avoids MEM/IF deadlock.
- **Sampling:** requests and addresses are sampled only in IDLE. Changes after grant are ignored.
- **Back-to-back:** a requester keeping REQ high in its ACK cycle presents a new request. That cycle is IDLE and is arbitrated normally.
- **Early REQ drop:** REQ dropped after grant (protocol violation) does not abort the transfer. The ACK still pulses.
- **Simultaneous requests in IDLE:** data served first; fetch is served in the IDLE following D_ACK, unless D_REQ is still high and wins again.

## Timing
- **Reset values:** all outputs 0 (M_REQ, M_RW, M_ADDR, M_WDATA, I_ACK, D_ACK, I_RDATA, D_RDATA). State is IDLE; starve counter is 0.
- **Reset mid-transfer:** M_REQ deasserts asynchronously and the transfer is abandoned with no ACK. The requester must re-request after reset.
- **Latency:** REQ sampled in IDLE at cycle t, M_REQ=1 at t+1, M_RDY at t+k (k≥1), ACK at t+k+1.
  - Minimum with M_RDY tied high: ACK at t+2.
  - Maximum throughput: one access per 2 cycles.
- **ACK width:** never high for more than one cycle per transfer. I_ACK and D_ACK are never high together.
- **M_RDY while M_REQ=0:** ignored.

## Configuration
- **TOY_MEM_ARB_FAIR_EN defined:**
  - A starve counter increments on each data grant made while I_REQ=1, saturating at STARVE_MAX.
  - It clears on each fetch grant.
  - In IDLE, if counter == STARVE_MAX and I_REQ=1, fetch is granted even with D_REQ=1.
- **TOY_MEM_ARB_FAIR_EN undefined:** strict data priority; no counter logic.

## Structure
- **Shared package toy_mem_pkg:**
  - State encoding: IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2.
  - RW encoding: RW_RD=1'b0, RW_WR=1'b1.
  - Default AW/DW constants.
- **Sub-module toy_arb_starve_ctr:** saturating counter plus force-fetch flag. Instantiated only under TOY_MEM_ARB_FAIR_EN.

## Test plan
- **Reset:** RST high during IBUSY with M_ADDR=0x10 → M_REQ=0 immediately, no I_ACK after release, all outputs 0.
- **Single fetch:** I_REQ=1, I_ADDR=0x40, M_RDY=1, M_RDATA=0xDEADBEEF → M_REQ at t+1, I_ACK at t+2, I_RDATA=0xDEADBEEF.
- **Write:** D_REQ=1, D_RW=1, D_ADDR=0x80, D_WDATA=0x12345678, M_RDY delayed 3 cycles → M_RW=1, M_ADDR/M_WDATA stable for 3 cycles, D_ACK at t+4, D_RDATA unchanged.
- **Collision:** I_REQ and D_REQ (read 0x90) rise together → data first (D_ACK), then fetch (I_ACK). ACKs are never coincident.
- **Starvation, macro defined, STARVE_MAX=3:** D_REQ and I_REQ held high continuously → exactly 3 D_ACKs, then 1 I_ACK, repeating.
- **Starvation, macro undefined, same stimulus:** no I_ACK until D_REQ drops.
